// File: rtl/core_step_ctrl.sv
// ============================================================================
// core_step_ctrl : run/step/breakpoint/register-dump sequencer for the RV64 core
// Revision 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module core_step_ctrl #(
    parameter int CNT_W     = 16,
    parameter int DUMP_WAIT = 2
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_arg,
    input  logic             bp_en,
    input  logic [63:0]      bp_pc,
    input  logic [63:0]      core_pc,
    output logic             core_run,
    output logic             core_step,
    output logic [4:0]       debug_reg_addr,
    input  logic [63:0]      debug_reg_data,
    output logic             dump_valid,
    output logic [4:0]       dump_idx,
    output logic [63:0]      dump_data,
    output logic             busy,
    output logic             halted_on_bp,
    output logic [CNT_W-1:0] retired_cnt
);

    localparam int         W_W       = (DUMP_WAIT < 1) ? 1 : $clog2(DUMP_WAIT + 1);
    localparam logic [1:0] c_OP_HALT = 2'd0;
    localparam logic [1:0] c_OP_RUN  = 2'd1;
    localparam logic [1:0] c_OP_STEP = 2'd2;
    localparam logic [1:0] c_OP_DUMP = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_STEP = 2'd2,
        S_DUMP = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               first_q, first_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic [4:0]         idx_q, idx_d;
    logic [W_W-1:0]     w_q, w_d;
    logic               halted_q, halted_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic               dv_q, dv_d;
    logic [4:0]         didx_q, didx_d;
    logic [63:0]        ddata_q, ddata_d;

    logic w_cmd_ready;
    logic w_accept;
    logic w_bp_hit;
    logic w_run;
    logic w_step;

    // first_q masks the breakpoint for one cycle so a resume from bp_pc can issue it
    assign w_bp_hit    = bp_en && (core_pc == bp_pc) && !first_q;
    assign w_cmd_ready = aresetn && ((state_q == S_IDLE) ||
                                     ((state_q == S_RUN) && (cmd_op == c_OP_HALT)));
    assign w_accept    = cmd_valid && w_cmd_ready;
    assign w_run       = (state_q == S_RUN) && !w_bp_hit && !w_accept;
    assign w_step      = (state_q == S_STEP) && !w_bp_hit;

    always_comb begin
        state_d   = state_q;
        first_d   = 1'b0;
        rem_d     = rem_q;
        idx_d     = idx_q;
        w_d       = w_q;
        halted_d  = halted_q;
        dv_d      = 1'b0;
        didx_d    = didx_q;
        ddata_d   = ddata_q;
        retired_d = retired_q + CNT_W'(w_run | w_step);

        if (w_accept) begin
            halted_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    case (cmd_op)
                        c_OP_RUN: begin
                            state_d = S_RUN;
                            first_d = 1'b1;
                        end
                        c_OP_STEP: begin
                            rem_d = cmd_arg;
                            if (cmd_arg != '0) begin
                                state_d = S_STEP;
                                first_d = 1'b1;
                            end
                        end
                        c_OP_DUMP: begin
                            idx_d   = 5'd0;
                            w_d     = '0;
                            state_d = S_DUMP;
                        end
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                if (w_accept) begin
                    state_d = S_IDLE;
                end else if (w_bp_hit) begin
                    halted_d = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            S_STEP: begin
                if (w_bp_hit) begin
                    halted_d = 1'b1;
                    rem_d    = '0;
                    state_d  = S_IDLE;
                end else begin
                    rem_d = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DUMP: begin
                // address has been stable for DUMP_WAIT cycles when w_q reaches the limit
                if (w_q == W_W'(DUMP_WAIT)) begin
                    dv_d    = 1'b1;
                    didx_d  = idx_q;
                    ddata_d = debug_reg_data;
                    idx_d   = idx_q + 5'd1;
                    w_d     = '0;
                    if (idx_q == 5'd31) begin
                        state_d = S_IDLE;
                    end
                end else begin
                    w_d = w_q + W_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= S_IDLE;
            first_q   <= 1'b0;
            rem_q     <= '0;
            idx_q     <= 5'd0;
            w_q       <= '0;
            halted_q  <= 1'b0;
            retired_q <= '0;
            dv_q      <= 1'b0;
            didx_q    <= 5'd0;
            ddata_q   <= 64'd0;
        end else begin
            state_q   <= state_d;
            first_q   <= first_d;
            rem_q     <= rem_d;
            idx_q     <= idx_d;
            w_q       <= w_d;
            halted_q  <= halted_d;
            retired_q <= retired_d;
            dv_q      <= dv_d;
            didx_q    <= didx_d;
            ddata_q   <= ddata_d;
        end
    end

    assign cmd_ready      = w_cmd_ready;
    assign core_run       = w_run;
    assign core_step      = w_step;
    assign debug_reg_addr = (state_q == S_DUMP) ? idx_q : 5'd0;
    assign dump_valid     = dv_q;
    assign dump_idx       = didx_q;
    assign dump_data      = ddata_q;
    assign busy           = (state_q != S_IDLE);
    assign halted_on_bp   = halted_q;
    assign retired_cnt    = retired_q;

endmodule

`default_nettype wire

// File: tb/tb_core_step_ctrl.sv
// ============================================================================
// tb_core_step_ctrl : scoreboard bench for core_step_ctrl (issue and dump streams)
// Revision 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_core_step_ctrl;

    localparam logic [1:0] c_HALT = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_STEP = 2'd2;
    localparam logic [1:0] c_DUMP = 2'd3;

    logic        clk = 1'b0;
    logic        aresetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_arg;
    logic        bp_en;
    logic [63:0] bp_pc;
    logic [63:0] core_pc;
    logic        core_run;
    logic        core_step;
    logic [4:0]  debug_reg_addr;
    logic [63:0] debug_reg_data;
    logic        dump_valid;
    logic [4:0]  dump_idx;
    logic [63:0] dump_data;
    logic        busy;
    logic        halted_on_bp;
    logic [15:0] retired_cnt;

    // narrow-counter instance for the wrap test
    logic        cmd_valid4;
    logic        cmd_ready4;
    logic [1:0]  cmd_op4;
    logic [3:0]  cmd_arg4;
    logic        bp_en4;
    logic        core_run4;
    logic        core_step4;
    logic [4:0]  debug_reg_addr4;
    logic        dump_valid4;
    logic [4:0]  dump_idx4;
    logic [63:0] dump_data4;
    logic        busy4;
    logic        halted_on_bp4;
    logic [3:0]  retired_cnt4;

    logic        pc_set;
    logic [63:0] pc_set_val;
    logic [63:0] pc_q;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic        is_step;
        logic [63:0] pc;
    } issue_t;
    typedef struct {
        logic [4:0]  idx;
        logic [63:0] data;
    } dump_t;

    issue_t iq[$];
    dump_t  dq[$];
    time    last_dv_t;

    always #5 clk = ~clk;

    core_step_ctrl #(.CNT_W(16), .DUMP_WAIT(2)) dut (
        .clk(clk), .aresetn(aresetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_arg(cmd_arg), .bp_en(bp_en), .bp_pc(bp_pc),
        .core_pc(core_pc), .core_run(core_run), .core_step(core_step),
        .debug_reg_addr(debug_reg_addr), .debug_reg_data(debug_reg_data),
        .dump_valid(dump_valid), .dump_idx(dump_idx), .dump_data(dump_data),
        .busy(busy), .halted_on_bp(halted_on_bp), .retired_cnt(retired_cnt)
    );

    core_step_ctrl #(.CNT_W(4), .DUMP_WAIT(2)) dut4 (
        .clk(clk), .aresetn(aresetn), .cmd_valid(cmd_valid4), .cmd_ready(cmd_ready4),
        .cmd_op(cmd_op4), .cmd_arg(cmd_arg4), .bp_en(bp_en4), .bp_pc(bp_pc),
        .core_pc(core_pc), .core_run(core_run4), .core_step(core_step4),
        .debug_reg_addr(debug_reg_addr4), .debug_reg_data(debug_reg_data),
        .dump_valid(dump_valid4), .dump_idx(dump_idx4), .dump_data(dump_data4),
        .busy(busy4), .halted_on_bp(halted_on_bp4), .retired_cnt(retired_cnt4)
    );

    // core model: PC advances one instruction per issue cycle, registers hold idx*0x1111
    always @(posedge clk or negedge aresetn) begin
        if (!aresetn)                 pc_q <= 64'd0;
        else if (pc_set)              pc_q <= pc_set_val;
        else if (core_run || core_step) pc_q <= pc_q + 64'd4;
    end
    assign core_pc        = pc_q;
    assign debug_reg_data = {59'd0, debug_reg_addr} * 64'h1111;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor: pops expected issue / dump records whenever the DUT presents one
    always @(negedge clk) begin : mon
        issue_t ei;
        dump_t  ed;
        if (core_run || core_step) begin
            chk("run_step_exclusive", {63'd0, core_run && core_step}, 64'd0);
            if (iq.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL issue_unexpected: got pc %0h run %0b step %0b expected none",
                         core_pc, core_run, core_step);
            end else begin
                ei = iq.pop_front();
                chk("issue_kind", {63'd0, core_step}, {63'd0, ei.is_step});
                chk("issue_pc", core_pc, ei.pc);
            end
        end
        if (dump_valid) begin
            if (dq.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL dump_unexpected: got idx %0d expected none", dump_idx);
            end else begin
                ed = dq.pop_front();
                chk("dump_idx", {59'd0, dump_idx}, {59'd0, ed.idx});
                chk("dump_data", dump_data, ed.data);
                if (dump_idx != 5'd0) chk("dump_spacing", $time - last_dv_t, 64'd30);
            end
            last_dv_t = $time;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [15:0] arg);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        tick();
        cmd_valid = 1'b0;
        cmd_op    = c_HALT;
        cmd_arg   = 16'd0;
    endtask

    task automatic push_issue(input logic is_step, input logic [63:0] pc0, input int n);
        issue_t e;
        for (int i = 0; i < n; i++) begin
            e.is_step = is_step;
            e.pc      = pc0 + 64'(4 * i);
            iq.push_back(e);
        end
    endtask

    task automatic push_dump();
        dump_t e;
        for (int i = 0; i < 32; i++) begin
            e.idx  = 5'(i);
            e.data = 64'(i) * 64'h1111;
            dq.push_back(e);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        logic seen;
        aresetn = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_arg = 16'd0;
        bp_en = 1'b0; bp_pc = 64'd0; pc_set = 1'b0; pc_set_val = 64'd0;
        cmd_valid4 = 1'b0; cmd_op4 = 2'd0; cmd_arg4 = 4'd0; bp_en4 = 1'b0;
        last_dv_t = 0;
        tick(); tick();
        chk("rst_cmd_ready", {63'd0, cmd_ready}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_retired", {48'd0, retired_cnt}, 64'd0);
        chk("rst_dump", {58'd0, dump_valid, dump_idx}, 64'd0);
        aresetn = 1'b1;
        #1;
        chk("idle_cmd_ready", {63'd0, cmd_ready}, 64'd1);

        // free run, halted after 10 issue cycles
        push_issue(1'b0, 64'h0, 10);
        send(c_RUN, 16'd0);
        for (int i = 0; i < 10; i++) tick();
        cmd_valid = 1'b1; cmd_op = c_HALT;
        #1;
        chk("halt_gates_run", {63'd0, core_run}, 64'd0);
        tick();
        cmd_valid = 1'b0;
        chk("run10_retired", {48'd0, retired_cnt}, 64'd10);
        chk("run10_busy", {63'd0, busy}, 64'd0);

        // breakpoint at 0x20
        pc_set = 1'b1; pc_set_val = 64'h0; tick(); pc_set = 1'b0;
        bp_en = 1'b1; bp_pc = 64'h20;
        push_issue(1'b0, 64'h0, 8);
        send(c_RUN, 16'd0);
        seen = 1'b0;
        n = 0;
        while (busy && n < 50) begin
            if (core_pc == 64'h20) begin
                chk("bp_gates_run", {63'd0, core_run}, 64'd0);
                seen = 1'b1;
            end
            tick();
            n++;
        end
        chk("bp_reached", {63'd0, seen}, 64'd1);
        chk("bp_halted", {63'd0, halted_on_bp}, 64'd1);
        chk("bp_retired", {48'd0, retired_cnt}, 64'd18);
        push_issue(1'b1, 64'h20, 1);
        send(c_STEP, 16'd1);
        chk("resume_clears_halted", {63'd0, halted_on_bp}, 64'd0);
        tick();
        chk("step1_done", {63'd0, busy}, 64'd0);
        chk("step1_retired", {48'd0, retired_cnt}, 64'd19);
        bp_en = 1'b0;

        // STEP_N 5, then STEP_N 0
        push_issue(1'b1, 64'h24, 5);
        send(c_STEP, 16'd5);
        n = 0;
        while (busy && n < 20) begin
            tick();
            n++;
        end
        chk("step5_busy_cycles", 64'(n), 64'd5);
        chk("step5_retired", {48'd0, retired_cnt}, 64'd24);
        cmd_valid = 1'b1; cmd_op = c_STEP; cmd_arg = 16'd0;
        #1;
        chk("step0_ready", {63'd0, cmd_ready}, 64'd1);
        tick();
        cmd_valid = 1'b0; cmd_op = c_HALT;
        chk("step0_idle", {62'd0, busy, cmd_ready}, 64'd1);
        tick();
        chk("step0_retired", {48'd0, retired_cnt}, 64'd24);

        // full register dump
        push_dump();
        send(c_DUMP, 16'd0);
        n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        chk("dump_cycles", 64'(n), 64'd96);
        tick();
        chk("dump_queue_drained", 64'(dq.size()), 64'd0);
        chk("dump_hold", {dump_idx, dump_data[58:0]}, {5'd31, 59'(31 * 'h1111)});
        chk("dump_addr_idle", {59'd0, debug_reg_addr}, 64'd0);

        // reset mid STEP_N
        push_issue(1'b1, 64'h38, 100);
        send(c_STEP, 16'd100);
        for (int i = 0; i < 40; i++) tick();
        chk("step100_pulses_before_rst", 64'(iq.size()), 64'd60);
        aresetn = 1'b0;
        #1;
        chk("rst_step_outputs", {58'd0, core_step, core_run, busy, cmd_ready, halted_on_bp, dump_valid}, 64'd0);
        chk("rst_step_retired", {48'd0, retired_cnt}, 64'd0);
        iq.delete();
        tick();
        aresetn = 1'b1;
        tick();

        // reset mid DUMP
        push_dump();
        send(c_DUMP, 16'd0);
        for (int i = 0; i < 20; i++) tick();
        chk("dump_partial_progress", {63'd0, dump_idx != 5'd0}, 64'd1);
        aresetn = 1'b0;
        #1;
        chk("rst_dump_outputs", {52'd0, busy, dump_valid, debug_reg_addr, dump_idx[4:0]}, 64'd0);
        chk("rst_dump_data", dump_data, 64'd0);
        dq.delete();
        tick();
        aresetn = 1'b1;
        tick();

        // new RUN accepted after reset
        push_issue(1'b0, 64'h0, 3);
        send(c_RUN, 16'd0);
        chk("post_rst_run_busy", {63'd0, busy}, 64'd1);
        tick(); tick(); tick();
        cmd_valid = 1'b1; cmd_op = c_HALT;
        tick();
        cmd_valid = 1'b0;
        chk("post_rst_retired", {48'd0, retired_cnt}, 64'd3);

        // 4-bit counter wrap, and non-HALT refused while running
        cmd_valid4 = 1'b1; cmd_op4 = c_RUN;
        tick();
        cmd_valid4 = 1'b0; cmd_op4 = c_HALT;
        for (int i = 0; i < 17; i++) tick();
        cmd_valid4 = 1'b1; cmd_op4 = c_STEP;
        #1;
        chk("run_refuses_step", {62'd0, cmd_ready4, core_run4}, 64'd1);
        cmd_op4 = c_HALT;
        #1;
        chk("run4_halt_ready", {62'd0, cmd_ready4, core_run4}, 64'd2);
        tick();
        cmd_valid4 = 1'b0;
        chk("wrap_retired", {60'd0, retired_cnt4}, 64'd1);
        chk("wrap_busy", {63'd0, busy4}, 64'd0);

        tick();
        chk("issue_queue_drained", 64'(iq.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
